cla_add_sequencer: RTL

Multi-cycle wide adder/subtractor controller that steps a single 4-bit carry-lookahead slice across WIDTH-bit operands, one nibble per clock, least-significant nibble first. It sits between the ALU issue logic and the result bus, trading latency for area. It owns the slice carry chain, the operand and result shift registers, and a valid/ready handshake on both sides.

---
 rtl/cla_seq_pkg.sv | 32 +++
 rtl/cla_add_sequencer_slice.sv | 53 +++++
 rtl/cla_add_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cla_seq_pkg.sv
// ============================================================================
// Module      : cla_seq_pkg
// Description : Shared types and constants for the nibble-serial CLA sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_seq_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef logic [SLICE_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int unsigned num_slices(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_add_sequencer_slice.sv
// ============================================================================
// Module      : cla_slice_step
// Description : Combinational 4-bit carry-lookahead slice: g/p, C1..C4, sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_slice_step
    import cla_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_c0,
    output logic [SLICE_W-1:0] o_s,
    output logic               o_c3,
    output logic               o_c4
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic               w_c1;
    logic               w_c2;
    logic               w_c3;
    logic               w_c4;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_gp
        assign w_g[i] = i_a[i] & i_b[i];
        assign w_p[i] = i_a[i] ^ i_b[i];
    end

    // Fully flattened lookahead: every carry depends only on g/p and i_c0.
    assign w_c1 = w_g[0]
                | (w_p[0] & i_c0);
    assign w_c2 = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & i_c0);
    assign w_c3 = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c0);
    assign w_c4 = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c0);

    assign o_s  = w_p ^ {w_c3, w_c2, w_c1, i_c0};
    assign o_c3 = w_c3;
    assign o_c4 = w_c4;

endmodule

`default_nettype wire

// File: rtl/cla_add_sequencer.sv
// ============================================================================
// Module      : cla_add_sequencer
// Description : Nibble-serial WIDTH-bit add/subtract using one CLA slice,
//               valid/ready on both sides. Optional macro: CLA_SEQ_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_add_sequencer
    import cla_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned N_SLICES = num_slices(WIDTH);
    localparam int unsigned CNT_W    = $clog2(N_SLICES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_sub;
    nibble_t          w_s;
    logic             w_c3;
    logic             w_c4;
    logic [WIDTH-1:0] w_res_next;

`ifdef CLA_SEQ_SUB_EN
    assign w_sub = sub;
`else
    logic w_sub_unused;
    assign w_sub_unused = sub;
    assign w_sub        = 1'b0;
`endif

    cla_slice_step u_slice (
        .i_a  (r_opa[SLICE_W-1:0]),
        .i_b  (r_opb[SLICE_W-1:0]),
        .i_c0 (r_carry),
        .o_s  (w_s),
        .o_c3 (w_c3),
        .o_c4 (w_c4)
    );

    // Result fills from the top so the first (LS) nibble lands at bit 0 after N shifts.
    assign w_res_next = {w_s, r_res[WIDTH-1:SLICE_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_opa   <= a;
                        r_opb   <= w_sub ? ~b : b;
                        r_carry <= w_sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_opa   <= r_opa >> SLICE_W;
                    r_opb   <= r_opb >> SLICE_W;
                    r_res   <= w_res_next;
                    r_carry <= w_c4;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_sum       <= w_res_next;
                        r_cout      <= w_c4;
                        r_ovf       <= w_c3 ^ w_c4;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire
